// File: rtl/mq_pkg.sv
// Shared types and the B-register step function for the MQ coder byte-out stage.
package mq_pkg;

    localparam logic [7:0] BYTE_FF = 8'hFF;
    localparam int         C_W     = 44;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic       push;
        logic [7:0] out_byte;
        logic [7:0] b_next;
        logic [3:0] ct;
    } step_t;

    // A byte following 0xFF only carries 7 bits, so the next window is one bit shorter.
    function automatic step_t mq_step(input logic [7:0]  b,
                                      input logic        b_valid,
                                      input logic [27:0] c,
                                      input logic        a);
        step_t      r;
        logic [7:0] b_inc;
        logic       unused_c;
        unused_c   = ^{c[27], c[18:0]};
        b_inc      = b + 8'd1;
        r.push     = b_valid;
        r.out_byte = b;
        r.b_next   = c[26:19];
        r.ct       = 4'd8;
        if (b == BYTE_FF) begin
            r.b_next = {1'b0, c[26:20]};
            r.ct     = 4'd7;
        end else if (a && (b_inc == BYTE_FF)) begin
            r.out_byte = BYTE_FF;
            r.b_next   = {1'b0, c[26:20]};
            r.ct       = 4'd7;
        end else if (a) begin
            r.out_byte = b_inc;
        end
        return r;
    endfunction

endpackage

// File: rtl/mq_byte_fifo.sv
// Circular byte FIFO with two ordered write ports and one read port.
module mq_byte_fifo
    import mq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en0,
    input  logic [7:0]                   wr_data0,
    input  logic                         wr_en1,
    input  logic [7:0]                   wr_data1,
    input  logic                         rd_ready,
    output logic [7:0]                   rd_data,
    output logic                         rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]  free_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_p1;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop;

    assign rd_valid = (count_q != '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign free_cnt = CNT_W'(FIFO_DEPTH) - count_q;
    assign pop      = rd_valid & rd_ready;

    // Port 1 is only ever used together with port 0 and lands in the slot after it.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_p1 = wr_ptr_q + PTR_W'(1);
        if (wr_en0) mem_d[wr_ptr_q]  = wr_data0;
        if (wr_en1) mem_d[wr_ptr_p1] = wr_data1;
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_en0) + PTR_W'(wr_en1);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(wr_en0) + CNT_W'(wr_en1) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mq_byte_out.sv
// MQ coder byte-out stage: B register update, 0xFF stuffing, carry absorption and flush.
module mq_byte_out
    import mq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     renor,
    input  logic [C_W-1:0] cout,
    input  logic           addb,
    input  logic           flush,
    output logic           bff_bo,
    output logic           bfe_bo,
    output logic [7:0]     byte_data,
    output logic           byte_valid,
    input  logic           byte_ready,
    output logic           done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t           state_q, state_d;
    logic [7:0]       b_q, b_d;
    logic             b_valid_q, b_valid_d;
    logic             bff_q, bff_d;
    logic [CNT_W-1:0] free_cnt;
    logic             wr_en0, wr_en1;
    logic [7:0]       wr_data0, wr_data1;
    logic             transfer;
    logic [27:0]      c1, c2;
    step_t            s1, s2;
    logic             unused_bits;

    assign unused_bits = ^{cout[43:36], s2.ct};

    // Step 2 always follows a real byte, so its push is never suppressed.
    always_comb begin
        c1 = (renor == 2'd2) ? cout[35:8] : cout[27:0];
        s1 = mq_step(b_q, b_valid_q, c1, addb);
        c2 = (s1.ct == 4'd8) ? {1'b0, cout[26:8], 8'b0} : {1'b0, cout[27:8], 7'b0};
        s2 = mq_step(s1.b_next, 1'b1, c2, 1'b0);
    end

    assign in_ready = (state_q == ST_RUN) && (free_cnt >= CNT_W'(2));
    assign transfer = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        b_d       = b_q;
        b_valid_d = b_valid_q;
        wr_en0    = 1'b0;
        wr_en1    = 1'b0;
        wr_data0  = s1.out_byte;
        wr_data1  = s2.out_byte;
        case (state_q)
            ST_RUN: begin
                if (transfer) begin
                    case (renor)
                        2'd1: begin
                            wr_en0    = s1.push;
                            b_d       = s1.b_next;
                            b_valid_d = 1'b1;
                        end
                        2'd2: begin
                            wr_en0 = 1'b1;
                            wr_en1 = s1.push;
                            if (!s1.push) wr_data0 = s2.out_byte;
                            b_d       = s2.b_next;
                            b_valid_d = 1'b1;
                        end
                        default: ;
                    endcase
                    if (flush) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (free_cnt != '0) begin
                    wr_en0   = b_valid_q && (b_q != BYTE_FF);
                    wr_data0 = b_q;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                b_d       = 8'h00;
                b_valid_d = 1'b0;
                state_d   = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        bff_d = b_valid_d && (b_d == BYTE_FF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            b_q       <= 8'h00;
            b_valid_q <= 1'b0;
            bff_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            b_q       <= b_d;
            b_valid_q <= b_valid_d;
            bff_q     <= bff_d;
        end
    end

    assign bff_bo = bff_q;
    assign bfe_bo = b_valid_q;
    assign done   = (state_q == ST_DONE);

    mq_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en0   (wr_en0),
        .wr_data0 (wr_data0),
        .wr_en1   (wr_en1),
        .wr_data1 (wr_data1),
        .rd_ready (byte_ready),
        .rd_data  (byte_data),
        .rd_valid (byte_valid),
        .free_cnt (free_cnt)
    );

endmodule

// File: tb/tb_mq_byte_out.sv
// Directed bench for mq_byte_out with a byte scoreboard fed by the stimulus and drained by a monitor.
module tb_mq_byte_out;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  renor;
    logic [43:0] cout;
    logic        addb;
    logic        flush;
    logic        bff_bo;
    logic        bfe_bo;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        done;

    logic [7:0]  expQ[$];
    int          checks = 0;
    int          errors = 0;
    int          doneCount = 0;

    mq_byte_out #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .renor      (renor),
        .cout       (cout),
        .addb       (addb),
        .flush      (flush),
        .bff_bo     (bff_bo),
        .bfe_bo     (bfe_bo),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [43:0] actual, input logic [43:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Called at posedge+1; the transfer lands on the following edge.
    task automatic applyStimulus(input logic [1:0] r, input logic [43:0] c, input logic a, input logic f,
                                 input bit p0, input logic [7:0] e0, input bit p1, input logic [7:0] e1);
        int waitCnt = 0;
        in_valid = 1'b1;
        renor    = r;
        cout     = c;
        addb     = a;
        flush    = f;
        while (!in_ready && waitCnt < 50) begin
            @(posedge clk);
            #1;
            waitCnt++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_ready_timeout actual=0 required=1");
        end else begin
            if (p0) expQ.push_back(e0);
            if (p1) expQ.push_back(e1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (byte_valid && byte_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL byte_unexpected actual=%02h required=none", byte_data);
            end else begin
                checkOutput("byte_out", {36'd0, byte_data}, {36'd0, expQ.pop_front()});
            end
        end
        if (done) doneCount++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; renor = 2'd0; cout = '0;
        addb = 1'b0; flush = 1'b0; byte_ready = 1'b1;
        idle(3);
        rst = 1'b0;
        checkOutput("rst_bfe", bfe_bo, 0);
        checkOutput("rst_bff", bff_bo, 0);
        checkOutput("rst_byte_valid", byte_valid, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_in_ready", in_ready, 1);

        // Dummy byte: nothing pushed, B becomes B4.
        applyStimulus(2'd1, 44'h5A00000, 1'b0, 1'b0, 0, 8'h00, 0, 8'h00);
        checkOutput("first_bfe", bfe_bo, 1);
        checkOutput("first_bff", bff_bo, 0);
        applyStimulus(2'd1, 44'h1E00000, 1'b0, 1'b0, 1, 8'hB4, 0, 8'h00);
        applyStimulus(2'd1, 44'h0900000, 1'b1, 1'b0, 1, 8'h3D, 0, 8'h00);
        applyStimulus(2'd1, 44'h7F00000, 1'b0, 1'b0, 1, 8'h12, 0, 8'h00);
        checkOutput("bff_fe", bff_bo, 0);
        applyStimulus(2'd1, 44'h5A00000, 1'b1, 1'b0, 1, 8'hFF, 0, 8'h00);
        checkOutput("bff_after_carry", bff_bo, 0);
        applyStimulus(2'd1, 44'h7F80000, 1'b0, 1'b0, 1, 8'h5A, 0, 8'h00);
        checkOutput("bff_set", bff_bo, 1);
        applyStimulus(2'd1, 44'h5A00000, 1'b0, 1'b0, 1, 8'hFF, 0, 8'h00);
        checkOutput("bff_after_stuff", bff_bo, 0);
        applyStimulus(2'd1, 44'h0800000, 1'b0, 1'b0, 1, 8'h5A, 0, 8'h00);

        // Two bytes per transfer, normal and stuffed first step.
        applyStimulus(2'd2, 44'h0ABCDEF00, 1'b0, 1'b0, 1, 8'h10, 1, 8'h15);
        applyStimulus(2'd2, 44'h0, 1'b1, 1'b0, 1, 8'h7A, 1, 8'h00);
        applyStimulus(2'd1, 44'h7F80000, 1'b0, 1'b0, 1, 8'h00, 0, 8'h00);
        checkOutput("bff_before_r2", bff_bo, 1);
        applyStimulus(2'd2, 44'h2468ACE00, 1'b0, 1'b0, 1, 8'hFF, 1, 8'h24);
        applyStimulus(2'd0, 44'h7F80000, 1'b1, 1'b0, 0, 8'h00, 0, 8'h00);
        applyStimulus(2'd3, 44'h7F80000, 1'b1, 1'b0, 0, 8'h00, 0, 8'h00);
        checkOutput("bff_after_r0", bff_bo, 0);
        idle(4);

        // Backpressure: three bytes fill the FIFO to count 3.
        byte_ready = 1'b0;
        applyStimulus(2'd1, 44'h0880000, 1'b0, 1'b0, 1, 8'h68, 0, 8'h00);
        applyStimulus(2'd1, 44'h1100000, 1'b0, 1'b0, 1, 8'h11, 0, 8'h00);
        applyStimulus(2'd1, 44'h1980000, 1'b0, 1'b0, 1, 8'h22, 0, 8'h00);
        checkOutput("full_in_ready", in_ready, 0);
        idle(10);
        checkOutput("hold_in_ready", in_ready, 0);
        checkOutput("hold_byte_valid", byte_valid, 1);
        byte_ready = 1'b1;
        idle(5);
        checkOutput("drained_in_ready", in_ready, 1);

        // Flush with trailing FF: discarded.
        applyStimulus(2'd1, 44'h7F80000, 1'b0, 1'b0, 1, 8'h33, 0, 8'h00);
        applyStimulus(2'd0, 44'h0, 1'b0, 1'b1, 0, 8'h00, 0, 8'h00);
        checkOutput("flush_in_ready", in_ready, 0);
        idle(5);
        checkOutput("flush_ff_done", doneCount, 1);
        checkOutput("flush_ff_bfe", bfe_bo, 0);

        // Flush with B=42: emitted by the FLUSH state.
        applyStimulus(2'd1, 44'h2100000, 1'b0, 1'b1, 0, 8'h00, 0, 8'h00);
        expQ.push_back(8'h42);
        idle(5);
        checkOutput("flush_42_done", doneCount, 2);

        // Reset during FLUSH: queued byte discarded, no done pulse.
        byte_ready = 1'b0;
        applyStimulus(2'd1, 44'h5A00000, 1'b0, 1'b0, 0, 8'h00, 0, 8'h00);
        applyStimulus(2'd1, 44'h2100000, 1'b0, 1'b1, 0, 8'h00, 0, 8'h00);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checkOutput("rst_flush_byte_valid", byte_valid, 0);
        checkOutput("rst_flush_bfe", bfe_bo, 0);
        checkOutput("rst_flush_in_ready", in_ready, 1);
        byte_ready = 1'b1;
        idle(5);
        checkOutput("rst_flush_done", doneCount, 2);

        applyStimulus(2'd1, 44'h0900000, 1'b0, 1'b0, 0, 8'h00, 0, 8'h00);
        applyStimulus(2'd1, 44'h5A00000, 1'b0, 1'b0, 1, 8'h12, 0, 8'h00);
        idle(5);
        checkOutput("scoreboard_empty", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mq_byte_out.md
# mq_byte_out

Byte-out stage of the MQ arithmetic coder, directly downstream of the C-register unit. Each accepted cycle it takes the renormalised C window, the renormalisation byte count and the carry flag, and updates the pending byte register B. It performs 0xFF bit-stuffing and carry absorption into B, and pushes completed bytes into an output FIFO with a valid/ready handshake. It returns `bff_bo` / `bfe_bo` to the C unit and terminates the codestream on flush.

## Interface
- `FIFO_DEPTH`, default 4 (entries, power of two, ≥2): output byte FIFO depth.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  C-unit result valid this cycle.
- `in_ready`  out  1  block can accept; equals (state==RUN) & (free slots ≥2).
- `renor`  in  2  bytes to emit: 0, 1 or 2; value 3 is treated as 0.
- `cout`  in  44  renormalised C value from the C unit.
- `addb`  in  1  carry into B (C ≥ 0x8000000) for the first emitted byte.
- `flush`  in  1  terminate after this transfer.
- `bff_bo`  out  1  b_valid & (B==8'hFF).
- `bfe_bo`  out  1  b_valid: B holds a real byte, not the initial dummy.
- `byte_data`  out  8  FIFO head.
- `byte_valid`  out  1  FIFO non-empty.
- `byte_ready`  in  1  consumer accepts head.
- `done`  out  1  one-cycle pulse, one cycle after the final byte is pushed.

## Operation
- **State:** `b_reg[7:0]`, `b_valid`, FSM {RUN, FLUSH, DONE}, FIFO.
- **Reset values:** b_reg=0, b_valid=0, state=RUN, FIFO empty, done=0, byte_valid=0, bff_bo=0, bfe_bo=0.
- **Transfer:** in_valid & in_ready. The renor=0 case with flush=0 changes nothing.
- **Step(c[27:0], a)** with B=b_reg:
  - B==FF: push B; B'={1'b0,c[26:20]}; ct=7.
  - else if a and B+1==FF: push FF; B'={1'b0,c[26:20]}; ct=7.
  - else if a: push B+1; B'=c[26:19]; ct=8.
  - else: push B; B'=c[26:19]; ct=8.
  - The push is suppressed when b_valid=0 (dummy byte); B+1 on the dummy is discarded.
  - After the step, b_valid=1.
- **renor=1:** Step(cout[27:0], addb).
- **renor=2:**
  - Step1 uses c1=cout[35:8] with a=addb, giving ct1.
  - Step2 uses c2 = ct1==8 ? {1'b0,cout[26:8],8'b0} : {1'b0,cout[27:8],7'b0}, with a=0.
  - Step2 sees the B' produced by step1.
  - Both steps complete in the same cycle, pushing up to 2 bytes in order.
- **Flush:** the transfer with flush=1 processes renor normally, then the FSM goes to FLUSH.
  - FLUSH (1 cycle): push b_reg if b_valid & b_reg≠FF (a trailing FF is discarded); then go to DONE.
  - DONE: assert done for 1 cycle; clear b_valid and b_reg; return to RUN.
- **FIFO:** circular, wrap-around pointers, count width $clog2(FIFO_DEPTH)+1.
  - Push and pop in the same cycle leave the count unchanged.
  - A pop occurs on byte_valid & byte_ready.
  - in_ready guarantees no overflow; FLUSH waits while the FIFO is full.
  - Data written into an empty FIFO becomes visible on byte_data the next cycle (registered).

## Timing
- B update and FIFO write land on the clock edge of the transfer.
- bff_bo/bfe_bo are registered and reflect the new B in the following cycle; the C unit uses them for the next transfer.
- Byte latency from transfer to byte_valid: 1 cycle.
- in_ready drops combinationally when free slots <2 or state≠RUN.
- Back-to-back transfers are allowed every cycle while in_ready=1.
- rst mid-operation: all state returns to reset values on the next edge; FIFO contents are discarded and no done pulse is produced.

## Structure
- Shared package `mq_pkg`: `BYTE_FF=8'hFF`, `C_W=44`, FSM enum type, and the step result struct {push, byte, b_next, ct}.
- Sub-module `mq_byte_fifo` (parameterised FIFO_DEPTH, 2-write port, 1-read port).
- The step function is a package function, instantiated twice combinationally.

## Test plan
- Reset, then renor=1, cout=28'h5A00000, addb=0 → no byte pushed (dummy), B=8'hB4, bfe_bo=1, bff_bo=0.
- B=8'h3C, renor=1, addb=1, cout[26:19]=8'h12 → byte 8'h3D out, B=8'h12.
- B=8'hFE, addb=1 → byte 8'hFF out, B={1'b0,c[26:20]}, bff_bo=0. Then B=8'hFF → byte FF and B'=7-bit field (stuffing).
- renor=2 with B=8'h10, addb=0, cout[35:8]=28'h0AB_CDEF → bytes 8'h10 then 8'h15 pushed in one cycle, B'=c2[26:19].
- byte_ready=0 with FIFO_DEPTH=4: fill until in_ready=0 at count 3, hold 10 cycles → no overflow, no data loss. Release → bytes drain in order.
- Flush with final B=8'hFF → no trailing FF emitted, done pulses once. Flush with B=8'h42 → 8'h42 emitted, then done. Asserting rst during FLUSH → no done pulse, byte_valid=0.
